// File: rtl/rv32_pkg.sv
// Shared RV32 core definitions: instruction width, bubble encoding,
// fetch FSM states and the IF/ID bundle.
package rv32_pkg;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic               valid;
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; flush beats hold beats load.
// Flush writes a bubble (valid=0, NOP instruction, pc kept).
module if_id_reg
    import rv32_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold_i,
    input  logic               flush_i,
    input  logic [31:0]        pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output if_id_t             if_id_o
);

    if_id_t if_id_d, if_id_q;

    always_comb begin
        if_id_d = if_id_q;
        if (flush_i) begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
        end else if (!hold_i) begin
            if_id_d.valid = 1'b1;
            if_id_d.pc    = pc_i;
            if_id_d.instr = instr_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_q.valid <= 1'b0;
            if_id_q.pc    <= 32'h0;
            if_id_q.instr <= NOP_INSTR;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign if_id_o = if_id_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: PC and fetch FSM feeding the IF/ID register.
// Define FETCH_PERF_CNT_EN to add saturating fetch/stall/flush counters.
module instr_fetch_unit
    import rv32_pkg::*;
#(
    parameter int          IMEM_AW   = 6,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               if_id_valid,
    output logic [31:0]        if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               halted,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stalled,
    output logic [31:0]        perf_flushed,
`endif
    output logic               misalign_err
);

    fetch_state_e state_d, state_q;
    logic [31:0]  pc_d, pc_q;
    logic         err_d, err_q;
    logic         hold, flush, advance, stalled, flushed;
    logic         misaligned, oob;
    if_id_t       if_id;

    assign misaligned = |redirect_pc[1:0];
    // Any pc bit above the memory index means we ran off the end.
    assign oob        = |pc_q[31:IMEM_AW+2];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        hold    = 1'b0;
        flush   = 1'b0;
        advance = 1'b0;
        stalled = 1'b0;
        flushed = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                hold    = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    flushed = 1'b1;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (stall) begin
                    hold    = 1'b1;
                    stalled = 1'b1;
                end else if (oob) begin
                    flush   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    advance = 1'b1;
                    pc_d    = pc_q + 32'd4;
                end
            end
            ST_HALT: begin
                flush = 1'b1;
                if (redirect_valid) begin
                    flushed = 1'b1;
                    if (misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        pc_d    = redirect_pc;
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                flush   = 1'b1;
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (hold),
        .flush_i (flush),
        .pc_i    (pc_q),
        .instr_i (imem_data),
        .if_id_o (if_id)
    );

    assign imem_addr    = pc_q[IMEM_AW+1:2];
    assign if_id_valid  = if_id.valid;
    assign if_id_pc     = if_id.pc;
    assign if_id_instr  = if_id.instr;
    assign halted       = (state_q == ST_HALT);
    assign misalign_err = err_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fet_q, stl_q, fls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fet_q <= 32'h0;
            stl_q <= 32'h0;
            fls_q <= 32'h0;
        end else begin
            if (advance && !(&fet_q)) fet_q <= fet_q + 32'd1;
            if (stalled && !(&stl_q)) stl_q <= stl_q + 32'd1;
            if (flushed && !(&fls_q)) fls_q <= fls_q + 32'd1;
        end
    end

    assign perf_fetched = fet_q;
    assign perf_stalled = stl_q;
    assign perf_flushed = fls_q;
`else
    logic unused_perf;
    assign unused_perf = advance ^ stalled ^ flushed;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 64-word combinational imem.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        halted;
    logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stalled, perf_flushed;
`endif

    logic [31:0] mem [64];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .halted         (halted),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_stalled   (perf_stalled),
        .perf_flushed   (perf_flushed),
`endif
        .misalign_err   (misalign_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc,
                            input logic [31:0] ins);
        chk({tag, ".valid"}, {31'b0, if_id_valid}, 32'd1);
        chk({tag, ".pc"}, if_id_pc, pc);
        chk({tag, ".instr"}, if_id_instr, ins);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"}, {31'b0, if_id_valid}, 32'd0);
        chk({tag, ".pc"}, if_id_pc, 32'h0);
        chk({tag, ".instr"}, if_id_instr, 32'h13);
        chk({tag, ".halted"}, {31'b0, halted}, 32'd0);
        chk({tag, ".err"}, {31'b0, misalign_err}, 32'd0);
        chk({tag, ".addr"}, {26'b0, imem_addr}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, ".pf"}, perf_fetched, 32'd0);
        chk({tag, ".ps"}, perf_stalled, 32'd0);
        chk({tag, ".pfl"}, perf_flushed, 32'd0);
`endif
    endtask

    task automatic run_t1(input string tag);
        tick();
        chk({tag, ".boot_valid"}, {31'b0, if_id_valid}, 32'd0);
        tick();
        chk_ifid({tag, ".e2"}, 32'h0, mem[0]);
        tick();
        chk_ifid({tag, ".e3"}, 32'h4, mem[1]);
        tick();
        chk_ifid({tag, ".e4"}, 32'h8, mem[2]);
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            mem[i] = 32'hA000_0000 | (i * 32'h0001_0101);

        #12;
        chk_reset("rst");
        rst_n = 1'b1;

        // 1: straight-line fetch
        run_t1("t1");
        chk("t1.addr", {26'b0, imem_addr}, 32'd3);

        // 2: stall holds IF/ID and imem address
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ifid("t2.hold", 32'h8, mem[2]);
            chk("t2.addr", {26'b0, imem_addr}, 32'd3);
        end
        stall = 1'b0;
        tick();
        chk_ifid("t2.rel", 32'hC, mem[3]);

        // 3: redirect wins over stall
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        tick();
        chk("t3.valid", {31'b0, if_id_valid}, 32'd0);
        chk("t3.instr", if_id_instr, 32'h13);
        stall = 1'b0;
        redirect_valid = 1'b0;
        tick();
        chk_ifid("t3.tgt", 32'h10, mem[4]);

        // 4: run to end of memory, no wrap
        for (int i = 0; i < 59; i++) tick();
        chk_ifid("t4.last", 32'hFC, mem[63]);
        tick();
        chk("t4.halted", {31'b0, halted}, 32'd1);
        chk("t4.valid", {31'b0, if_id_valid}, 32'd0);
        tick();
        chk("t4.nowrap", {31'b0, if_id_valid}, 32'd0);
        chk("t4.halted2", {31'b0, halted}, 32'd1);

        // 5: misaligned redirect, then aligned recovery
        redirect_valid = 1'b1;
        redirect_pc = 32'h22;
        tick();
        chk("t5.err", {31'b0, misalign_err}, 32'd1);
        chk("t5.halted", {31'b0, halted}, 32'd1);
        redirect_pc = 32'h0;
        tick();
        chk("t5.run", {31'b0, halted}, 32'd0);
        chk("t5.sticky", {31'b0, misalign_err}, 32'd1);
        chk("t5.bubble", {31'b0, if_id_valid}, 32'd0);
        redirect_valid = 1'b0;
        tick();
        chk_ifid("t5.fetch", 32'h0, mem[0]);
        chk("t5.sticky2", {31'b0, misalign_err}, 32'd1);

        // 6: async reset mid-stream
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("t6");
        #1;
        rst_n = 1'b1;
        run_t1("t6r");
`ifdef FETCH_PERF_CNT_EN
        chk("t6.pf", perf_fetched, 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
